// File: rtl/hevc_interp_pkg.sv
// Shared constants for the HEVC luma sub-pel interpolator: tap tables,
// phase/mode encodings, framing state type and the final-sample round/clip.
package hevc_interp_pkg;

   localparam int SUM_W = 16;

   localparam logic [1:0] FRAC_INT  = 2'd0;
   localparam logic [1:0] FRAC_Q1   = 2'd1;
   localparam logic [1:0] FRAC_HALF = 2'd2;
   localparam logic [1:0] FRAC_Q3   = 2'd3;

   localparam logic MODE_FINAL = 1'b0;
   localparam logic MODE_INTER = 1'b1;

   // Tap k lives at bits [8k +: 8]; listed here from k=7 down to k=0.
   localparam logic [63:0] TAP_INT = {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0};
   localparam logic [63:0] TAP_A   = {8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
   localparam logic [63:0] TAP_B   = {-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
   localparam logic [63:0] TAP_C   = {-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OPEN = 1'b1
   } blk_state_e;

   function automatic logic signed [7:0] tap_coef(input logic [1:0] frac, input logic [2:0] k);
      logic [63:0] tbl;
      case (frac)
         FRAC_Q1:   tbl = TAP_A;
         FRAC_HALF: tbl = TAP_B;
         FRAC_Q3:   tbl = TAP_C;
         default:   tbl = TAP_INT;
      endcase
      return $signed(tbl[{k, 3'b000} +: 8]);
   endfunction

   // (S + 32) >>> 6 computed one bit wider so the +32 cannot wrap.
   function automatic logic [7:0] round_clip(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W:0] t;
      t = ($signed({s[SUM_W-1], s}) + 17'sd32) >>> 6;
      if (t < 0) begin
         return 8'd0;
      end else if (t > 17'sd255) begin
         return 8'hFF;
      end
      return t[7:0];
   endfunction

endpackage

// File: rtl/subpel_fir8.sv
// One combinational 8-tap luma lane: eight unsigned pixels and a phase in,
// signed 16-bit weighted sum out.
module subpel_fir8
   import hevc_interp_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic [8*PIX_W-1:0]       i_pix,
   input  logic [1:0]               i_frac,
   output logic signed [SUM_W-1:0]  o_sum
);

   always_comb begin
      o_sum = '0;
      for (int k = 0; k < 8; k++) begin
         o_sum = o_sum + SUM_W'(tap_coef(i_frac, 3'(k)))
                       * $signed({{(SUM_W-PIX_W){1'b0}}, i_pix[k*PIX_W +: PIX_W]});
      end
   end

endmodule

// File: rtl/hevc_subpel_row_filter.sv
// Horizontal sub-pel row filter: BLK_W lanes per beat, two-stage stallable
// pipe (lane sums, then round/clip), block framing and a sticky framing error.
module hevc_subpel_row_filter
   import hevc_interp_pkg::*;
#(
   parameter int BLK_W = 8,
   parameter int BLK_H = 8,
   parameter int PIX_W = 8,
   parameter int OUT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 frac,
   input  logic                       mode,
   input  logic [(BLK_W+7)*PIX_W-1:0] in_row,
   input  logic                       in_sof,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [BLK_W*OUT_W-1:0]     out_row,
   output logic                       out_sob,
   output logic                       out_eob,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_frame,
   output logic                       o_dbg_state
);

   localparam int LAST_ROW = BLK_H + 6;
   localparam int CNT_W    = $clog2(BLK_H + 7);

   // Handshake: a beat moves on a rising edge where valid & ready are both 1;
   // ready never depends on valid, and a stalled output holds every out_* field.
   logic                          w_adv;
   logic                          w_accept;
   blk_state_e                    r_state, w_state_nxt;
   logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
   logic [1:0]                    r_frac, w_frac_nxt;
   logic                          r_mode, w_mode_nxt;
   logic                          r_err, w_err_nxt;
   logic                          w_sob, w_eob;
   logic [BLK_W-1:0][SUM_W-1:0]   w_sum;
   logic                          r_s1_valid, r_s1_sob, r_s1_eob, r_s1_mode;
   logic [BLK_W-1:0][SUM_W-1:0]   r_s1_sum;
   logic [BLK_W*OUT_W-1:0]        w_out_row;

   assign w_adv       = !out_valid | out_ready;
   assign in_ready    = w_adv;
   assign w_accept    = in_valid & w_adv;
   assign err_frame   = r_err;
   assign o_dbg_state = (r_state == ST_OPEN);

   // Framing: the phase used for this beat is the newly latched one on a sof.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_frac_nxt  = r_frac;
      w_mode_nxt  = r_mode;
      w_err_nxt   = r_err;
      w_sob       = 1'b0;
      w_eob       = 1'b0;
      if (w_accept) begin
         if (in_sof) begin
            if (r_state == ST_OPEN) begin
               w_err_nxt = 1'b1;
            end
            w_frac_nxt  = frac;
            w_mode_nxt  = mode;
            w_sob       = 1'b1;
            w_state_nxt = ST_OPEN;
            w_cnt_nxt   = CNT_W'(1);
         end else if (r_state == ST_OPEN) begin
            if (r_cnt == CNT_W'(LAST_ROW)) begin
               w_eob       = 1'b1;
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end else begin
            w_err_nxt = 1'b1;
         end
      end
   end

   for (genvar j = 0; j < BLK_W; j++) begin : g_lane
      subpel_fir8 #(.PIX_W(PIX_W)) u_fir (
         .i_pix  (in_row[j*PIX_W +: 8*PIX_W]),
         .i_frac (w_frac_nxt),
         .o_sum  (w_sum[j])
      );
   end

   always_comb begin
      w_out_row = '0;
      for (int j = 0; j < BLK_W; j++) begin
         w_out_row[j*OUT_W +: OUT_W] = r_s1_mode ? OUT_W'($signed(r_s1_sum[j]))
                                                 : OUT_W'(round_clip($signed(r_s1_sum[j])));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_frac     <= FRAC_INT;
         r_mode     <= MODE_FINAL;
         r_err      <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_sob   <= 1'b0;
         r_s1_eob   <= 1'b0;
         r_s1_mode  <= MODE_FINAL;
         out_valid  <= 1'b0;
         out_row    <= '0;
         out_sob    <= 1'b0;
         out_eob    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_frac  <= w_frac_nxt;
         r_mode  <= w_mode_nxt;
         r_err   <= w_err_nxt;
         if (w_adv) begin
            r_s1_valid <= w_accept;
            r_s1_sum   <= w_sum;
            r_s1_sob   <= w_sob;
            r_s1_eob   <= w_eob;
            r_s1_mode  <= w_mode_nxt;
            out_valid  <= r_s1_valid;
            out_row    <= w_out_row;
            out_sob    <= r_s1_sob;
            out_eob    <= r_s1_eob;
         end
      end
   end

endmodule

// File: tb/tb_hevc_subpel_row_filter.sv
// Bench for hevc_subpel_row_filter: randomized rows and framing against a
// lane-by-lane arithmetic model, with literal pins on the model itself.
module tb_hevc_subpel_row_filter;

   localparam int BLK_W = 8;
   localparam int BLK_H = 8;
   localparam int PIX_W = 8;
   localparam int OUT_W = 16;
   localparam int IN_W  = (BLK_W+7)*PIX_W;
   localparam int ROW_W = BLK_W*OUT_W;
   localparam int EXP_W = ROW_W + 2;
   localparam int ROWS  = BLK_H + 7;

   logic              clk;
   logic              rst;
   logic [1:0]        frac;
   logic              mode;
   logic [IN_W-1:0]   in_row;
   logic              in_sof;
   logic              in_valid;
   logic              in_ready;
   logic [ROW_W-1:0]  out_row;
   logic              out_sob;
   logic              out_eob;
   logic              out_valid;
   logic              out_ready;
   logic              err_frame;
   logic              o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int bp_mode  = 0;
   int sof_cyc  = -1;
   int eob_cyc  = -1;

   logic [EXP_W-1:0] exp_q[$];
   int               stamp_q[$];
   bit               latf_q[$];

   bit m_open, m_err;
   int m_cnt, m_frac, m_mode;

   hevc_subpel_row_filter #(
      .BLK_W(BLK_W), .BLK_H(BLK_H), .PIX_W(PIX_W), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .rst(rst), .frac(frac), .mode(mode), .in_row(in_row),
      .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
      .out_row(out_row), .out_sob(out_sob), .out_eob(out_eob),
      .out_valid(out_valid), .out_ready(out_ready), .err_frame(err_frame),
      .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- model ----------------
   function automatic int pix_of(input logic [IN_W-1:0] r, input int i);
      return int'(r[i*PIX_W +: PIX_W]);
   endfunction

   function automatic int model_lane(input logic [IN_W-1:0] r, input int f, input int md, input int j);
      int taps[3][8];
      int s;
      int v;
      taps = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
               '{-1, 4, -11, 40, 40, -11, 4, -1},
               '{0, 1, -5, 17, 58, -10, 4, -1}};
      if (f == 0) begin
         s = pix_of(r, j+3) * 64;
      end else begin
         s = 0;
         for (int k = 0; k < 8; k++) s += taps[f-1][k] * pix_of(r, j+k);
      end
      if (md != 0) return s;
      v = (s + 32) >>> 6;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      return v;
   endfunction

   function automatic logic [ROW_W-1:0] model_row(input logic [IN_W-1:0] r, input int f, input int md);
      logic [ROW_W-1:0] o;
      o = '0;
      for (int j = 0; j < BLK_W; j++) o[j*OUT_W +: OUT_W] = 16'(model_lane(r, f, md, j));
      return o;
   endfunction

   function automatic logic [IN_W-1:0] flat_row(input int v);
      logic [IN_W-1:0] r;
      for (int i = 0; i < BLK_W+7; i++) r[i*PIX_W +: PIX_W] = 8'(v);
      return r;
   endfunction

   function automatic logic [IN_W-1:0] step_row();
      logic [IN_W-1:0] r;
      for (int i = 0; i < BLK_W+7; i++) r[i*PIX_W +: PIX_W] = (i < 5) ? 8'd0 : 8'd255;
      return r;
   endfunction

   function automatic logic [IN_W-1:0] ramp_row();
      logic [IN_W-1:0] r;
      for (int i = 0; i < BLK_W+7; i++) r[i*PIX_W +: PIX_W] = 8'(i);
      return r;
   endfunction

   function automatic logic [IN_W-1:0] rand_row();
      logic [IN_W-1:0] r;
      for (int i = 0; i < BLK_W+7; i++) r[i*PIX_W +: PIX_W] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   task automatic check(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   logic [EXP_W-1:0] e;
   logic [ROW_W-1:0] prev_row;
   bit               prev_stall, prev_sob, prev_eob, sob_b, eob_b, lf;
   int               st, ef, em;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         exp_q.delete();
         stamp_q.delete();
         latf_q.delete();
         m_open = 0; m_err = 0; m_cnt = 0; m_frac = 0; m_mode = 0;
         prev_stall = 0;
      end else begin
         check("in_ready", in_ready, !out_valid || out_ready);
         check("err_frame", err_frame, m_err);
         check("dbg_state", o_dbg_state, m_open);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_row", out_row, prev_row);
            check("stall_sob", out_sob, prev_sob);
            check("stall_eob", out_eob, prev_eob);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_row: got %0h expected no row", out_row);
            end else begin
               e  = exp_q.pop_front();
               st = stamp_q.pop_front();
               lf = latf_q.pop_front();
               check("out_row", out_row, e[ROW_W-1:0]);
               check("out_sob", out_sob, e[ROW_W+1]);
               check("out_eob", out_eob, e[ROW_W]);
               if (lf) check("latency", cyc - st, 2);
               if (out_eob) eob_cyc = cyc;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_row   = out_row;
         prev_sob   = out_sob;
         prev_eob   = out_eob;
         if (in_valid && in_ready) begin
            sob_b = 0;
            eob_b = 0;
            if (in_sof) begin
               if (m_open) m_err = 1;
               m_open  = 1;
               m_frac  = int'(frac);
               m_mode  = int'(mode);
               m_cnt   = 0;
               sob_b   = 1;
               sof_cyc = cyc;
            end else if (!m_open) begin
               m_err = 1;
            end
            ef = m_frac;
            em = m_mode;
            if (m_open) begin
               if (m_cnt == ROWS-1) begin
                  eob_b  = 1;
                  m_open = 0;
               end
               m_cnt++;
            end
            exp_q.push_back({sob_b, eob_b, model_row(in_row, ef, em)});
            stamp_q.push_back(cyc);
            latf_q.push_back(bp_mode == 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [IN_W-1:0] r, input bit sof, input int f, input int md);
      int n;
      bit acc;
      n = 0;
      acc = 0;
      in_row = r; in_sof = sof; frac = f[1:0]; mode = md[0]; in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic set_bp(input int m);
      wait_drain();
      bp_mode = m;
      idle(2);
   endtask

   task automatic send_block(input int f, input int md, input int nrows);
      for (int r = 0; r < nrows; r++) begin
         if (r == 0)      send(flat_row(100), 1, f, md);
         else if (r == 1) send(step_row(), 0, $urandom_range(0, 3), $urandom_range(0, 1));
         else if (r == 2) send(ramp_row(), 0, $urandom_range(0, 3), $urandom_range(0, 1));
         else             send(rand_row(), 0, $urandom_range(0, 3), $urandom_range(0, 1));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; frac = 2'd0; mode = 1'b0; in_row = '0;
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_row", out_row, '0);
      check("rst_out_sob", out_sob, 1'b0);
      check("rst_out_eob", out_eob, 1'b0);
      check("rst_err_frame", err_frame, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      for (int f = 1; f <= 3; f++) begin
         check("pin_flat_m0", model_lane(flat_row(100), f, 0, 3), 100);
         check("pin_flat_m1", model_lane(flat_row(100), f, 1, 0), 6400);
      end
      check("pin_step_l0", model_lane(step_row(), 2, 0, 0), 0);
      check("pin_step_l1", model_lane(step_row(), 2, 0, 1), 128);
      check("pin_ramp_m0_l0", model_lane(ramp_row(), 0, 0, 0), 3);
      check("pin_ramp_m0_l7", model_lane(ramp_row(), 0, 0, 7), 10);
      check("pin_ramp_m1_l0", model_lane(ramp_row(), 0, 1, 0), 192);
      check("pin_ramp_m1_l5", model_lane(ramp_row(), 0, 1, 5), 192 + 64*5);

      // Isolated block: 15 rows need 17 cycles from first accept to last output.
      send_block(2, 0, ROWS);
      wait_drain();
      check("block_cycles", eob_cyc - sof_cyc, ROWS + 1);

      // Back-to-back blocks over every phase and mode.
      for (int f = 0; f < 4; f++) begin
         for (int md = 0; md < 2; md++) send_block(f, md, ROWS);
      end
      wait_drain();
      check("no_err_yet", err_frame, 1'b0);

      set_bp(1);
      send_block(1, 0, ROWS);
      send_block(3, 1, ROWS);

      // sof on beat 5 restarts the block; a stray beat with no block open.
      set_bp(0);
      send_block(1, 0, 5);
      send_block(2, 1, ROWS);
      send(rand_row(), 0, 0, 0);
      wait_drain();
      check("err_set", err_frame, 1'b1);

      // Reset mid-block with rows in flight.
      send_block(3, 0, 6);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_row", out_row, '0);
      check("mid_rst_sob", out_sob, 1'b0);
      check("mid_rst_eob", out_eob, 1'b0);
      check("mid_rst_err", err_frame, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle(4);
      send_block(0, 1, ROWS);

      set_bp(2);
      for (int b = 0; b < 12; b++) begin
         int nr;
         nr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ROWS-1) : ROWS;
         for (int r = 0; r < nr; r++) begin
            send(rand_row(), r == 0, $urandom_range(0, 3), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
